// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_pkg
//  Brief    : Shared constants, state encoding and sizing helpers for the
//             I2S sample transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int unsigned c_state_w = 1;
    localparam logic [c_state_w-1:0] c_st_idle = 1'b0;
    localparam logic [c_state_w-1:0] c_st_run  = 1'b1;

    // One frame carries the same sample in both the left and right slots.
    function automatic int unsigned frame_bits(input int unsigned sample_width);
        return 2 * sample_width;
    endfunction

    function automatic int unsigned bit_cnt_width(input int unsigned sample_width);
        return $clog2(2 * sample_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_bclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_bclk_gen
//  Brief    : Divides clk down to bclk and flags the cycle before each bclk
//             edge so the owner can update data in step with bclk.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_bclk_gen #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bclk,
    output logic rise_evt,
    output logic fall_evt
);

    localparam int unsigned c_div_w = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(BCLK_DIV - 1);

    logic [c_div_w-1:0] r_div_cnt;
    logic               r_bclk;
    logic               w_wrap;

    assign w_wrap = run && (r_div_cnt == c_div_last);

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + c_div_w'(1);
        end
    end

    // Strobes lead the bclk edge by one cycle, so registers updated on them
    // change on the same clk edge as bclk itself.
    assign rise_evt = w_wrap && !r_bclk;
    assign fall_evt = w_wrap && r_bclk;
    assign bclk     = r_bclk;

endmodule
`default_nettype wire

// File: rtl/i2s_sample_tx.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_sample_tx
//  Brief    : Requests one mono sample per frame and shifts it out MSB first,
//             left-justified, in both the left and right slots.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_sample_tx
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned BCLK_DIV     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    mute,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    output logic                    new_frame,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    busy
);

    localparam int unsigned c_frame_bits = frame_bits(SAMPLE_WIDTH);
    localparam int unsigned c_cnt_w      = bit_cnt_width(SAMPLE_WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last    = c_cnt_w'(c_frame_bits - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_half_m1 = c_cnt_w'(SAMPLE_WIDTH - 1);

    logic [c_state_w-1:0]    r_state;
    logic [c_cnt_w-1:0]      r_bit_cnt;
    logic [c_frame_bits-1:0] r_shift;
    logic [SAMPLE_WIDTH-1:0] r_held;
    logic                    r_new_frame;
    logic                    r_lrclk;
    logic                    r_busy;

    logic w_run;
    logic w_fall;
    logic w_unused_rise;
    logic w_last_bit;
    logic w_load;
    logic w_stop;

    assign w_run = (r_state == c_st_run);

    // The receiver latches on the rising edge; the transmitter has nothing to do there.
    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk      (clk),
        .reset    (reset),
        .run      (w_run),
        .bclk     (bclk),
        .rise_evt (w_unused_rise),
        .fall_evt (w_fall)
    );

    assign w_last_bit = w_fall && (r_bit_cnt == c_cnt_last);
    assign w_load     = ((r_state == c_st_idle) && enable) || (w_last_bit && enable);
    assign w_stop     = w_last_bit && !enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_held      <= '0;
            r_new_frame <= 1'b0;
            r_lrclk     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_new_frame <= 1'b0;
            if (w_load) begin
                // Frame boundary: transmit the previously held sample, capture the next.
                r_state     <= c_st_run;
                r_busy      <= 1'b1;
                r_new_frame <= 1'b1;
                r_bit_cnt   <= '0;
                r_lrclk     <= 1'b0;
                r_shift     <= {r_held, r_held};
                r_held      <= mute ? '0 : sample_in;
            end else if (w_stop) begin
                r_state   <= c_st_idle;
                r_busy    <= 1'b0;
                r_bit_cnt <= '0;
                r_lrclk   <= 1'b0;
                r_shift   <= '0;
            end else if (w_fall) begin
                r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
                r_shift   <= {r_shift[c_frame_bits-2:0], 1'b0};
                if (r_bit_cnt == c_cnt_half_m1) begin
                    r_lrclk <= 1'b1;
                end
            end
        end
    end

    assign new_frame = r_new_frame;
    assign lrclk     = r_lrclk;
    assign sdata     = r_shift[c_frame_bits-1];
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2s_sample_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_sample_tx
//  Brief    : Directed self-checking bench for i2s_sample_tx.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_sample_tx;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        enable    = 1'b0;
    logic        mute      = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic        new_frame;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] cap_left;
    logic [15:0] cap_right;
    int          n_rise;
    int          n_left;
    int          n_hi;
    int          first_rise;
    int          last_rise;
    int          n_nf;
    int          nf_at;
    logic        busy_end;

    always #5 clk = ~clk;

    i2s_sample_tx #(
        .SAMPLE_WIDTH (16),
        .BCLK_DIV     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mute      (mute),
        .sample_in (sample_in),
        .new_frame (new_frame),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .sdata     (sdata),
        .busy      (busy)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one 256-cycle frame window starting just after a new_frame cycle,
    // decoding sdata on each bclk rise into the slot chosen by lrclk.
    task automatic capture_frame(input int drop_at);
        logic prev;
        prev       = bclk;
        cap_left   = '0;
        cap_right  = '0;
        n_rise     = 0;
        n_left     = 0;
        n_hi       = 0;
        first_rise = -1;
        last_rise  = -1;
        n_nf       = 0;
        nf_at      = -1;
        for (int i = 1; i <= 256; i++) begin
            step(1);
            if (i == drop_at) enable = 1'b0;
            if (bclk) n_hi++;
            if (bclk && !prev) begin
                n_rise++;
                if (first_rise < 0) first_rise = i;
                last_rise = i;
                if (!lrclk) begin
                    n_left++;
                    cap_left = {cap_left[14:0], sdata};
                end else begin
                    cap_right = {cap_right[14:0], sdata};
                end
            end
            if (new_frame) begin
                n_nf++;
                nf_at = i;
            end
            prev = bclk;
        end
        busy_end = busy;
    endtask

    task automatic check_frame(input string tag, input logic [15:0] exp, input logic continues);
        chk({tag, "_left"},       cap_left,  exp);
        chk({tag, "_right"},      cap_right, exp);
        chk({tag, "_rises"},      n_rise,    32);
        chk({tag, "_left_rises"}, n_left,    16);
        if (continues) begin
            chk({tag, "_nf_count"}, n_nf,     1);
            chk({tag, "_nf_at"},    nf_at,    256);
            chk({tag, "_busy"},     busy_end, 1'b1);
        end else begin
            chk({tag, "_nf_count"}, n_nf,     0);
            chk({tag, "_busy"},     busy_end, 1'b0);
        end
    endtask

    task automatic quiet(input int n, input string tag);
        int active;
        active = 0;
        repeat (n) begin
            step(1);
            if (new_frame || bclk || lrclk || sdata || busy) active++;
        end
        chk(tag, active, 0);
    endtask

    initial begin
        // Power-on reset, then idle with enable low.
        step(3);
        chk("reset_outs", {new_frame, bclk, lrclk, sdata, busy}, 5'b00000);
        reset = 1'b0;
        quiet(10, "idle_quiet");

        // Start: boundary on the first cycle of RUN captures A5C3.
        enable    = 1'b1;
        sample_in = 16'hA5C3;
        step(1);
        chk("start_nf",   new_frame, 1'b1);
        chk("start_busy", busy,      1'b1);
        chk("start_bclk", bclk,      1'b0);
        sample_in = 16'h0000;

        capture_frame(-1);
        check_frame("f0_zero", 16'h0000, 1'b1);
        chk("bclk_first_rise", first_rise,             4);
        chk("bclk_rise_span",  last_rise - first_rise, 248);
        chk("bclk_high_cycles", n_hi,                  128);

        sample_in = 16'h7FFF;
        mute      = 1'b1;
        capture_frame(-1);
        check_frame("f1_a5c3", 16'hA5C3, 1'b1);

        mute = 1'b0;
        capture_frame(-1);
        check_frame("f2_zero", 16'h0000, 1'b1);

        sample_in = 16'h3C5A;
        capture_frame(-1);
        check_frame("f3_muted", 16'h0000, 1'b1);

        sample_in = 16'hC0DE;
        capture_frame(-1);
        check_frame("f4_7fff", 16'h7FFF, 1'b1);

        // Drop enable in the middle of bit 10; the frame must still finish.
        sample_in = 16'h1234;
        capture_frame(84);
        check_frame("f5_stop", 16'h3C5A, 1'b0);
        chk("stop_outs", {bclk, lrclk, sdata}, 3'b000);
        quiet(20, "stopped_quiet");

        // Restart: first frame carries the sample held from before the stop.
        enable    = 1'b1;
        sample_in = 16'h1111;
        step(1);
        chk("restart_nf", new_frame, 1'b1);
        capture_frame(-1);
        check_frame("f6_held", 16'hC0DE, 1'b1);

        // Reset around bit 20 of a running frame (right slot active).
        step(164);
        chk("pre_reset_lrclk", lrclk, 1'b1);
        reset = 1'b1;
        step(1);
        chk("midrst_outs", {new_frame, bclk, lrclk, sdata, busy}, 5'b00000);
        step(2);
        chk("midrst_outs_hold", {new_frame, bclk, lrclk, sdata, busy}, 5'b00000);
        reset = 1'b0;
        step(1);
        chk("release_nf", new_frame, 1'b1);
        capture_frame(-1);
        check_frame("f7_after_rst", 16'h0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
